// File: rtl/i2c_s_if.sv
// User-side handshake between i2c_s and the register/FIFO consumer behind it.
`timescale 1ns/1ps
interface i2c_s_if;
  logic [7:0] tx_data;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       tx_load;
  logic       busy;

  modport slave  (input tx_data, output rx_data, rx_valid, tx_load, busy);
  modport master (output tx_data, input rx_data, rx_valid, tx_load, busy);
endinterface

// File: rtl/i2c_s.sv
// I2C target: oversampled SCL/SDA, START/STOP detect, 7-bit address match, byte rx/tx.
// Optional I2C_S_LSB_FIRST_EN: LSB-first byte order with R/W as the first bit on the wire.
`timescale 1ns/1ps
module i2c_s #(
  parameter logic [6:0] DEV_ADDR = 7'h50
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        s_SCL,
  inout  wire         s_SDA,
  i2c_s_if.slave      usr
);

  typedef enum logic [2:0] {
    ST_IDLE, ST_ADDR, ST_ADDR_ACK, ST_WRITE, ST_WR_ACK, ST_READ, ST_RD_ACK, ST_WAIT_STOP
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] shift_q, shift_d;
  logic       sda_oe_q, sda_oe_d;
  logic       busy_q, busy_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_valid_q, rx_valid_d;
  logic       tx_load_q, tx_load_d;

  logic scl_s1_q, scl_s2_q, scl_h_q;
  logic sda_s1_q, sda_s2_q, sda_h_q;

  // Synchronizers reset to the idle-bus level so reset never fakes an edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_s1_q <= 1'b1; scl_s2_q <= 1'b1; scl_h_q <= 1'b1;
      sda_s1_q <= 1'b1; sda_s2_q <= 1'b1; sda_h_q <= 1'b1;
    end else begin
      scl_s1_q <= s_SCL; scl_s2_q <= scl_s1_q; scl_h_q <= scl_s2_q;
      sda_s1_q <= s_SDA; sda_s2_q <= sda_s1_q; sda_h_q <= sda_s2_q;
    end
  end

  logic scl_rise, scl_fall, start_ev, stop_ev;
  assign scl_rise = scl_s2_q & ~scl_h_q;
  assign scl_fall = ~scl_s2_q & scl_h_q;
  assign start_ev = scl_s2_q & scl_h_q & sda_h_q & ~sda_s2_q;
  assign stop_ev  = scl_s2_q & scl_h_q & ~sda_h_q & sda_s2_q;

  logic [7:0] shift_in;
  logic       tx_first;
  logic       tx_next;
  logic [7:0] shift_out;
`ifdef I2C_S_LSB_FIRST_EN
  assign shift_in  = {sda_s2_q, shift_q[7:1]};
  assign tx_first  = usr.tx_data[0];
  assign tx_next   = shift_q[1];
  assign shift_out = {1'b0, shift_q[7:1]};
`else
  assign shift_in  = {shift_q[6:0], sda_s2_q};
  assign tx_first  = usr.tx_data[7];
  assign tx_next   = shift_q[6];
  assign shift_out = {shift_q[6:0], 1'b0};
`endif

  // In both byte orders the address byte lands as {addr[6:0], rw}
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    sda_oe_d   = sda_oe_q;
    busy_d     = busy_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    tx_load_d  = 1'b0;
    if (stop_ev) begin
      state_d  = ST_IDLE;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
      cnt_d    = '0;
    end else if (start_ev) begin
      state_d  = ST_ADDR;
      sda_oe_d = 1'b0;
      cnt_d    = '0;
    end else begin
      case (state_q)
        ST_IDLE: ;
        ST_ADDR: if (scl_rise) begin
          shift_d = shift_in;
          if (cnt_q == 4'd7) begin
            state_d = ST_ADDR_ACK;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
        // cnt 0: waiting for the fall that opens the ACK slot; 1: ACK being driven
        ST_ADDR_ACK: if (scl_fall) begin
          if (cnt_q == 4'd0) begin
            if (shift_q[7:1] == DEV_ADDR) begin
              sda_oe_d = 1'b1;
              busy_d   = 1'b1;
              cnt_d    = 4'd1;
            end else begin
              busy_d  = 1'b0;
              state_d = ST_WAIT_STOP;
            end
          end else if (shift_q[0]) begin
            state_d   = ST_READ;
            shift_d   = usr.tx_data;
            sda_oe_d  = ~tx_first;
            tx_load_d = 1'b1;
            cnt_d     = 4'd1;
          end else begin
            state_d  = ST_WRITE;
            sda_oe_d = 1'b0;
            cnt_d    = '0;
          end
        end
        ST_WRITE: if (scl_rise) begin
          shift_d = shift_in;
          if (cnt_q == 4'd7) begin
            rx_data_d  = shift_in;
            rx_valid_d = 1'b1;
            state_d    = ST_WR_ACK;
            cnt_d      = '0;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
        ST_WR_ACK: if (scl_fall) begin
          if (cnt_q == 4'd0) begin
            sda_oe_d = 1'b1;
            cnt_d    = 4'd1;
          end else begin
            sda_oe_d = 1'b0;
            state_d  = ST_WRITE;
            cnt_d    = '0;
          end
        end
        // cnt counts bits already placed on the wire
        ST_READ: if (scl_fall) begin
          if (cnt_q == 4'd8) begin
            sda_oe_d = 1'b0;
            state_d  = ST_RD_ACK;
            cnt_d    = '0;
          end else begin
            shift_d  = shift_out;
            sda_oe_d = ~tx_next;
            cnt_d    = cnt_q + 4'd1;
          end
        end
        ST_RD_ACK: begin
          if (scl_rise && cnt_q == 4'd0) begin
            if (!sda_s2_q) begin
              cnt_d = 4'd1;
            end else begin
              busy_d  = 1'b0;
              state_d = ST_WAIT_STOP;
            end
          end else if (scl_fall && cnt_q == 4'd1) begin
            state_d   = ST_READ;
            shift_d   = usr.tx_data;
            sda_oe_d  = ~tx_first;
            tx_load_d = 1'b1;
            cnt_d     = 4'd1;
          end
        end
        ST_WAIT_STOP: sda_oe_d = 1'b0;
        default: begin
          state_d  = ST_IDLE;
          sda_oe_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      shift_q    <= '0;
      sda_oe_q   <= 1'b0;
      busy_q     <= 1'b0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      tx_load_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      sda_oe_q   <= sda_oe_d;
      busy_q     <= busy_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      tx_load_q  <= tx_load_d;
    end
  end

  assign s_SDA        = sda_oe_q ? 1'b0 : 1'bz;
  assign usr.rx_data  = rx_data_q;
  assign usr.rx_valid = rx_valid_q;
  assign usr.tx_load  = tx_load_q;
  assign usr.busy     = busy_q;

endmodule
